// File: rtl/ret_instruction.sv
// ret_instruction
// Return-from-subroutine unit. Pops the return address that the call unit
// pushed onto the downward-growing stack: reads stack RAM at sp+1 through a
// one-cycle-latency synchronous read port, then presents the restored PC and
// the incremented SP with a one-cycle done pulse. All outputs are registered.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        return request, accepted only when not mid-operation
//   sp           current stack pointer, captured on the accepting edge
//   busy         high from the accepting edge until the edge that ends done
//   mem_rd_en    stack RAM read strobe
//   mem_addr     stack RAM read address (qualify with mem_rd_en)
//   mem_rd_data  stack RAM read data, valid the cycle after mem_rd_en
//   new_pc       restored return address
//   new_sp       stack pointer after the pop
//   done         one-cycle completion pulse
//   underflow    pulses with done when the stack was empty
module ret_instruction #(
  parameter int PC_W = 19,
  parameter int SP_W = 8,
  parameter logic [SP_W-1:0] SP_EMPTY = {SP_W{1'b1}}
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [SP_W-1:0] sp,
  output logic            busy,
  output logic            mem_rd_en,
  output logic [SP_W-1:0] mem_addr,
  input  logic [PC_W-1:0] mem_rd_data,
  output logic [PC_W-1:0] new_pc,
  output logic [SP_W-1:0] new_sp,
  output logic            done,
  output logic            underflow
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WAIT,
    DONE
  } StateT;

  localparam logic [SP_W-1:0] SpOne = {{(SP_W-1){1'b0}}, 1'b1};

  StateT           r_state;
  logic [SP_W-1:0] r_spQ;
  logic            r_emptyPop;
  logic            r_busy;
  logic            r_memRdEn;
  logic [SP_W-1:0] r_memAddr;
  logic [PC_W-1:0] r_newPc;
  logic [SP_W-1:0] r_newSp;
  logic            r_done;
  logic            r_underflow;

  logic [SP_W-1:0] w_spInAddr;
  logic [SP_W-1:0] w_spQInc;
  logic            w_canAccept;

  assign w_spInAddr = sp + SpOne;
  assign w_spQInc   = r_spQ + SpOne;

  // DONE also accepts a new request so that start held high gives one
  // return every three cycles (two on underflow) instead of idling a cycle.
  assign w_canAccept = (r_state == IDLE) || (r_state == DONE);

  // An empty-stack pop skips READ and passes through WAIT with r_emptyPop
  // set, so its done pulse lands one edge after acceptance while new_pc and
  // new_sp are left untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_spQ       <= '0;
      r_emptyPop  <= 1'b0;
      r_busy      <= 1'b0;
      r_memRdEn   <= 1'b0;
      r_memAddr   <= '0;
      r_newPc     <= '0;
      r_newSp     <= SP_EMPTY;
      r_done      <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_done      <= 1'b0;
      r_underflow <= 1'b0;
      r_memRdEn   <= 1'b0;
      if (w_canAccept) begin
        if (start) begin
          r_spQ  <= sp;
          r_busy <= 1'b1;
          if (sp == SP_EMPTY) begin
            r_emptyPop <= 1'b1;
            r_state    <= WAIT;
          end else begin
            r_emptyPop <= 1'b0;
            r_memRdEn  <= 1'b1;
            r_memAddr  <= w_spInAddr;
            r_state    <= READ;
          end
        end else begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      end else begin
        case (r_state)
          READ: begin
            r_state <= WAIT;
          end
          WAIT: begin
            if (r_emptyPop) begin
              r_underflow <= 1'b1;
            end else begin
              r_newPc <= mem_rd_data;
              r_newSp <= w_spQInc;
            end
            r_done  <= 1'b1;
            r_state <= DONE;
          end
          default: begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        endcase
      end
    end
  end

  assign busy      = r_busy;
  assign mem_rd_en = r_memRdEn;
  assign mem_addr  = r_memAddr;
  assign new_pc    = r_newPc;
  assign new_sp    = r_newSp;
  assign done      = r_done;
  assign underflow = r_underflow;

endmodule
